// File: rtl/program_sequencer.sv
// Instruction sequencer for the 8-bit accumulator datapath: program memory,
// program counter and a valid/ready issue port that waits for writeback.
module program_sequencer #(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                   clock_pulse,
  input  logic                   resetn,
  input  logic                   load_en,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   run,
  input  logic                   step,
  input  logic                   clear,
  output logic                   issue_valid,
  output logic [INSTR_WIDTH-1:0] issue_instr,
  output logic [PC_WIDTH-1:0]    issue_pc,
  input  logic                   issue_ready,
  input  logic                   done,
  output logic                   halted,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [7:0]             retired,
  output logic [2:0]             state
);

  // state  | meaning
  // IDLE   | waiting for run/step; program loads accepted
  // FETCH  | latch memory[pc]; all-zero word halts
  // ISSUE  | present instruction until the datapath accepts it
  // WAIT   | waiting for writeback done; then advance pc
  // HALT   | HALT executed; loads accepted, clear returns to IDLE at pc 0
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int DEPTH = 1 << PC_WIDTH;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [7:0]             retired_q, retired_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   run_mode_q, run_mode_d;

  logic [INSTR_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   mem_we;

  assign mem_we     = load_en && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign fetch_word = mem_q[pc_q];

  // Program memory is deliberately outside the reset domain so a program survives resetn.
  always_ff @(posedge clock_pulse) begin
    if (mem_we) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      retired_q  <= '0;
      instr_q    <= '0;
      run_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      instr_q    <= instr_d;
      run_mode_q <= run_mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    instr_d    = instr_q;
    run_mode_d = run_mode_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          run_mode_d = 1'b1;
        end else if (step) begin
          state_d    = S_FETCH;
          run_mode_d = 1'b0;
        end
      end
      S_FETCH: begin
        instr_d = fetch_word;
        state_d = (fetch_word == '0) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          pc_d = pc_q + PC_WIDTH'(1);
          if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
          state_d = (run_mode_q && run) ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        if (clear) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registers so the datapath handshake cannot loop back combinationally.
  assign issue_valid = (state_q == S_ISSUE);
  assign issue_instr = instr_q;
  assign issue_pc    = pc_q;
  assign halted      = (state_q == S_HALT);
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule
